// File: rtl/ct_f_spsram_2048x144_ctrl.sv
// Access controller in front of the 2048x144 single-port SRAM wrapper.
// It zero-fills the array, accepts one valid/ready access per cycle and returns/holds read data.
`timescale 1ns/1ps
module ct_f_spsram_2048x144_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 144,
  parameter int INIT_EN    = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rdata_vld,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  acc_p0;
  logic                  rd_vld_p1;
  logic [DATA_WIDTH-1:0] hold_p1;

  // ---- stage p0 -> p1: FSM state, sweep counter, read-return tracking
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      cnt       <= '0;
      rd_vld_p1 <= 1'b0;
      hold_p1   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rd_vld_p1 <= acc_p0 & ~req_wr;
      if (rd_vld_p1) hold_p1 <= sram_q;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_done = 1'b0;
    req_rdy   = 1'b0;
    acc_p0    = 1'b0;
    sram_a    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_d    = '0;
    sram_wen  = '1;
    case (state)
      ST_INIT: begin
        sram_a    = cnt;
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == CNT_MAX) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        init_done = 1'b1;
        req_rdy   = ~init_req;
        acc_p0    = req_vld & ~init_req;
        if (acc_p0) begin
          sram_a   = req_addr;
          sram_cen = 1'b0;
          if (req_wr) begin
            sram_gwen = 1'b0;
            sram_d    = req_wdata;
            sram_wen  = ~req_wmask;
          end
        end
        // A restart request blocks this cycle's access; the sweep begins at 0 next cycle.
        if (init_req) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---- stage p1: the returning read passes straight through, otherwise the held copy
  assign rdata_vld = rd_vld_p1;
  assign rdata     = rd_vld_p1 ? sram_q : hold_p1;

endmodule

// File: doc/ct_f_spsram_2048x144_ctrl.md
Name: ct_f_spsram_2048x144_ctrl

Overview:
Access controller directly upstream of the 2048x144 single-port FPGA SRAM wrapper; it drives the wrapper's A/CEN/GWEN/D/WEN and consumes Q.
- Zero-initialises the whole array after reset or on request.
- Arbitrates a valid/ready request port, one access per cycle.
- Returns read data with a valid pulse and holds it stable until the next read completes.

Parameters:
ADDR_WIDTH, 11, SRAM address width (depth = 2^ADDR_WIDTH)
DATA_WIDTH, 144, SRAM data/mask width
INIT_EN, 1, 1 = run zero-init sweep after reset; 0 = enter RUN directly after reset

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  reset, asynchronous, active-low
init_req  in  1  single-cycle pulse, restart zero-init sweep (honoured in RUN only)
init_done  out  1  high while in RUN
req_vld  in  1  access request valid
req_rdy  out  1  controller can accept request this cycle
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  access address
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  DATA_WIDTH  active-high per-bit write enable
rdata_vld  out  1  read data valid pulse
rdata  out  DATA_WIDTH  read data, held after the pulse
sram_a  out  ADDR_WIDTH  to SRAM A
sram_cen  out  1  to SRAM CEN, active-low
sram_gwen  out  1  to SRAM GWEN, active-low global write
sram_d  out  DATA_WIDTH  to SRAM D
sram_wen  out  DATA_WIDTH  to SRAM WEN, active-low per bit
sram_q  in  DATA_WIDTH  from SRAM Q, synchronous read, valid the cycle after the access

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - state = INIT if INIT_EN else RUN; init counter = 0
  - init_done = !INIT_EN; req_rdy = !INIT_EN
  - rdata_vld = 0; rdata hold register = 0
- SRAM outputs are combinational from state and request.
  - Idle (no access): sram_cen = 1, sram_gwen = 1, sram_wen = all 1s, sram_d = 0, sram_a = 0.
- State INIT:
  - Each cycle issues one write: sram_a = cnt, sram_cen = 0, sram_gwen = 0, sram_wen = 0, sram_d = 0.
  - cnt increments by 1 each cycle. At cnt = 2^ADDR_WIDTH-1, the write issues, then the FSM moves to RUN; cnt wraps to 0.
  - Sweep takes exactly 2048 cycles. init_done rises the cycle after the last write.
  - req_rdy = 0 throughout; init_req is ignored.
- State RUN:
  - req_rdy = 1 unless init_req = 1 in that cycle.
  - Request accepted when req_vld & req_rdy. Accepted access drives sram_cen = 0 and sram_a = req_addr.
  - Write: sram_gwen = 0, sram_d = req_wdata, sram_wen = ~req_wmask.
  - Read: sram_gwen = 1, sram_wen = all 1s.
  - A write with req_wmask = 0 still asserts CEN and leaves the array unchanged.
  - init_req = 1 in RUN: the current-cycle request is not accepted (req_rdy = 0). INIT is entered next cycle with cnt = 0, init_done = 0.
- Read return:
  - A read accepted in cycle N gives rdata_vld = 1 in cycle N+1 for exactly one cycle.
  - In that cycle rdata = sram_q (combinational pass-through); the hold register captures sram_q at the end of N+1.
  - In all other cycles rdata = hold register. Data stays stable across later writes and idle cycles until the next read returns.
- Back-to-back reads in N and N+1 give rdata_vld in N+1 and N+2, each carrying its own address data. Throughput is 1 access/cycle, with no bubbles.
- Write then read of the same address in consecutive cycles returns the new data, because the array is updated at the edge ending the write cycle.
- Pending read vs init: a read accepted in cycle N followed by init_req in N+1 still returns valid data in N+1. The first init write occurs in N+2, so it cannot corrupt the return.
- Reset mid-sweep: INIT restarts at cnt = 0, and rdata_vld clears immediately.
- Writes produce no response.

Test Plan:
- Reset release with INIT_EN = 1 -> req_rdy = 0 for 2048 cycles, sram_a sweeps 0..2047 with CEN = GWEN = 0 and D = 0; init_done = 1 on cycle 2049. A subsequent read of addr 0x7FF returns 0.
- Write addr 0x123 data all-ones mask all-ones, then read 0x123 in the next cycle -> rdata_vld one cycle after the read, rdata = all-ones. rdata then holds all-ones through 5 idle cycles and an intervening write to 0x200.
- Write 0x055 with data all-ones, mask = 0x0...0FF -> a read returns 0x0...0FF. Bits above [7:0] stay 0, and sram_wen[143:8] = 1 during the write.
- Back-to-back reads of 0x001, 0x002, 0x003 (data 0xA, 0xB, 0xC) -> rdata_vld high 3 consecutive cycles with values 0xA, 0xB, 0xC, with no req_rdy deassertion.
- Read of 0x010 accepted, then init_req next cycle -> rdata_vld with the pre-init data. The following cycle starts the sweep at addr 0; init_done is low for 2048 cycles, and a later read of 0x010 = 0.
- cpurst_b asserted at sweep cnt = 1000 -> outputs return to their reset values immediately. After release, the sweep restarts at addr 0 and completes in 2048 cycles.
